// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : registered EX-stage ALU with valid/ready input handshake.
//
// Operations (func):
//   0 ADD  saturating src1 + src0
//   1 SUB  saturating src1 - src0 (src1 + ~src0 + 1)
//   2 AND  src1 & src0
//   3 NOR  ~(src1 | src0)
//   4 SLL  src1 << shamt, zero once shamt >= WIDTH
//   5 SRL  src1 >> shamt, zero once shamt >= WIDTH
//   6 SRA  src1 >>> shamt, all sign bits once shamt >= WIDTH
//   7 LHB  {src1 low half, src0 low half}
//   8 MUL  saturating signed multiply (only with ALU_MUL_EN defined)
//   other  reserved: dst=0, ov=0, zr=1
//
// Configuration macro: ALU_MUL_EN
//   defined   : iterative radix-2 Booth multiplier, WIDTH busy cycles per MUL
//   undefined : no multiplier; in_rdy tied high; func=8 behaves as reserved
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   in_vld   operands/func valid
//   in_rdy   unit can accept an operation this cycle
//   func     operation select (FW bits)
//   src0     operand 0
//   src1     operand 1
//   shamt    shift amount, zero-extended
//   out_vld  one-cycle pulse, dst/flags valid
//   dst      registered result
//   ov       registered saturation flag
//   zr       registered zero flag (dst == 0)
//   neg      registered sign flag (dst MSB)
//
// Single-cycle ops have latency 1 and may be accepted every cycle. A MUL
// holds in_rdy low for WIDTH cycles; its result appears on the edge that
// returns the unit to idle. dst and flags hold between results.
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 16,
   parameter int SHW   = 4,
   parameter int FW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [FW-1:0]    func,
   input  logic [WIDTH-1:0] src0,
   input  logic [WIDTH-1:0] src1,
   input  logic [SHW-1:0]   shamt,
   output logic             out_vld,
   output logic [WIDTH-1:0] dst,
   output logic             ov,
   output logic             zr,
   output logic             neg
);

   localparam int HW = WIDTH / 2;

   localparam logic [FW-1:0] F_ADD = FW'(0);
   localparam logic [FW-1:0] F_SUB = FW'(1);
   localparam logic [FW-1:0] F_AND = FW'(2);
   localparam logic [FW-1:0] F_NOR = FW'(3);
   localparam logic [FW-1:0] F_SLL = FW'(4);
   localparam logic [FW-1:0] F_SRL = FW'(5);
   localparam logic [FW-1:0] F_SRA = FW'(6);
   localparam logic [FW-1:0] F_LHB = FW'(7);
`ifdef ALU_MUL_EN
   localparam logic [FW-1:0] F_MUL = FW'(8);
`endif

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // Output registers
   logic             r_out_vld;
   logic [WIDTH-1:0] r_dst;
   logic             r_ov;
   logic             r_zr;
   logic             r_neg;

   // Single-cycle datapath
   logic             w_accept;
   logic             w_sub;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH-1:0] w_sum;
   logic             w_add_ovf;
   logic             w_sh_big;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ov;

   // Result write port shared by single-cycle ops and the multiplier
   logic             w_wr_en;
   logic [WIDTH-1:0] w_wr_val;
   logic             w_wr_ov;

   assign w_accept = in_vld & in_rdy;

   // Shared adder for ADD/SUB and the out-of-range shift detect
   always_comb begin
      w_sub     = (func == F_SUB);
      w_addend  = w_sub ? ~src0 : src0;
      w_sum     = src1 + w_addend + {{(WIDTH-1){1'b0}}, w_sub};
      // Signed overflow: both addends agree in sign but the sum does not.
      w_add_ovf = (src1[WIDTH-1] == w_addend[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != src1[WIDTH-1]);
      w_sh_big  = (32'(shamt) >= 32'(WIDTH));
   end

   // Single-cycle operation select and saturation
   always_comb begin
      w_alu_res = {WIDTH{1'b0}};
      w_alu_ov  = 1'b0;
      case (func)
         F_ADD, F_SUB: begin
            if (w_add_ovf) begin
               // Overflow direction follows the sign of src1 (shared by
               // both addends when overflow is possible).
               w_alu_res = src1[WIDTH-1] ? SAT_MIN : SAT_MAX;
               w_alu_ov  = 1'b1;
            end else begin
               w_alu_res = w_sum;
               w_alu_ov  = 1'b0;
            end
         end
         F_AND: w_alu_res = src1 & src0;
         F_NOR: w_alu_res = ~(src1 | src0);
         F_SLL: begin
            if (w_sh_big) begin
               w_alu_res = {WIDTH{1'b0}};
            end else begin
               w_alu_res = src1 << shamt;
            end
         end
         F_SRL: begin
            if (w_sh_big) begin
               w_alu_res = {WIDTH{1'b0}};
            end else begin
               w_alu_res = src1 >> shamt;
            end
         end
         F_SRA: begin
            if (w_sh_big) begin
               w_alu_res = {WIDTH{src1[WIDTH-1]}};
            end else begin
               w_alu_res = WIDTH'($signed(src1) >>> shamt);
            end
         end
         F_LHB: w_alu_res = {src1[HW-1:0], src0[HW-1:0]};
         default: begin
            // Reserved codes (and MUL when the multiplier is not built).
            w_alu_res = {WIDTH{1'b0}};
            w_alu_ov  = 1'b0;
         end
      endcase
   end

`ifdef ALU_MUL_EN
   localparam int              CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_mcand;   // multiplicand (src1)
   logic [WIDTH-1:0] r_mplier;  // multiplier (src0), low half of product
   logic [WIDTH:0]   r_acc;     // one guard bit keeps -2^(W-1) multiplicand exact
   logic             r_q1;      // Booth q[-1]
   logic [CW-1:0]    r_cnt;

   logic             w_is_mul;
   logic             w_mul_done;
   logic [WIDTH:0]   w_mcand_x;
   logic [WIDTH:0]   w_booth_sum;
   logic [WIDTH:0]   w_step_acc;
   logic [WIDTH-1:0] w_step_mplier;
   logic             w_step_q1;
   logic [2*WIDTH-1:0] w_prod;
   logic             w_prod_fits;
   logic [WIDTH-1:0] w_mul_res;
   logic             w_mul_ov;

   assign in_rdy     = (r_state == S_IDLE);
   assign w_is_mul   = (func == F_MUL);
   assign w_mul_done = (r_state == S_BUSY) && (r_cnt == LAST_STEP);

   // One radix-2 Booth step plus saturation of the resulting product
   always_comb begin
      w_mcand_x = {r_mcand[WIDTH-1], r_mcand};
      case ({r_mplier[0], r_q1})
         2'b01:   w_booth_sum = r_acc + w_mcand_x;
         2'b10:   w_booth_sum = r_acc - w_mcand_x;
         default: w_booth_sum = r_acc;
      endcase
      // Arithmetic right shift of {acc, mplier, q1}.
      w_step_acc    = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
      w_step_mplier = {w_booth_sum[0], r_mplier[WIDTH-1:1]};
      w_step_q1     = r_mplier[0];
      // Product is only meaningful after the final step; it fits in WIDTH
      // bits when the top WIDTH+1 bits are all copies of the sign.
      w_prod        = {w_step_acc[WIDTH-1:0], w_step_mplier};
      w_prod_fits   = (w_prod[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){w_prod[2*WIDTH-1]}});
      if (w_prod_fits) begin
         w_mul_res = w_prod[WIDTH-1:0];
         w_mul_ov  = 1'b0;
      end else begin
         w_mul_res = w_prod[2*WIDTH-1] ? SAT_MIN : SAT_MAX;
         w_mul_ov  = 1'b1;
      end
   end

   // Result write selection: finishing MUL, or an accepted single-cycle op
   always_comb begin
      w_wr_en  = 1'b0;
      w_wr_val = w_alu_res;
      w_wr_ov  = w_alu_ov;
      if (w_mul_done) begin
         w_wr_en  = 1'b1;
         w_wr_val = w_mul_res;
         w_wr_ov  = w_mul_ov;
      end else if (w_accept && !w_is_mul) begin
         w_wr_en  = 1'b1;
      end else begin
         w_wr_en  = 1'b0;
      end
   end
`else
   assign in_rdy = 1'b1;

   // Result write selection: every accepted op completes in one cycle
   always_comb begin
      w_wr_en  = w_accept;
      w_wr_val = w_alu_res;
      w_wr_ov  = w_alu_ov;
   end
`endif

   // Control FSM, multiplier state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_dst     <= {WIDTH{1'b0}};
         r_ov      <= 1'b0;
         r_zr      <= 1'b0;
         r_neg     <= 1'b0;
`ifdef ALU_MUL_EN
         r_state   <= S_IDLE;
         r_mcand   <= {WIDTH{1'b0}};
         r_mplier  <= {WIDTH{1'b0}};
         r_acc     <= {(WIDTH+1){1'b0}};
         r_q1      <= 1'b0;
         r_cnt     <= {CW{1'b0}};
`endif
      end else begin
         r_out_vld <= w_wr_en;
         if (w_wr_en) begin
            r_dst <= w_wr_val;
            r_ov  <= w_wr_ov;
            r_zr  <= (w_wr_val == {WIDTH{1'b0}});
            r_neg <= w_wr_val[WIDTH-1];
         end
`ifdef ALU_MUL_EN
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_mul) begin
                  r_mcand  <= src1;
                  r_mplier <= src0;
                  r_acc    <= {(WIDTH+1){1'b0}};
                  r_q1     <= 1'b0;
                  r_cnt    <= {CW{1'b0}};
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_acc    <= w_step_acc;
               r_mplier <= w_step_mplier;
               r_q1     <= w_step_q1;
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == LAST_STEP) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
`endif
      end
   end

   assign out_vld = r_out_vld;
   assign dst     = r_dst;
   assign ov      = r_ov;
   assign zr      = r_zr;
   assign neg     = r_neg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16). Directed vector table with
// constant expectations, hand sequences for reset and (when ALU_MUL_EN is
// defined) multi-cycle MUL behaviour, and random ops checked against an
// integer-arithmetic reference model.
module tb_alu_mc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_vld;
   logic        in_rdy;
   logic [3:0]  func;
   logic [15:0] src0;
   logic [15:0] src1;
   logic [3:0]  shamt;
   logic        out_vld;
   logic [15:0] dst;
   logic        ov;
   logic        zr;
   logic        neg;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mc #(.WIDTH(16), .SHW(4), .FW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .func(func), .src0(src0), .src1(src1), .shamt(shamt),
      .out_vld(out_vld), .dst(dst), .ov(ov), .zr(zr), .neg(neg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  f;
      logic [15:0] s1;
      logic [15:0] s0;
      logic [3:0]  sh;
      logic [15:0] ed;
      logic        eo;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: result computed from plain signed integer arithmetic.
   function automatic void ref_op(input logic [3:0] f, input logic [15:0] s1,
                                  input logic [15:0] s0, input logic [3:0] sh,
                                  output logic [15:0] d, output logic o);
      longint r;
      int     v;
      d = 16'h0000;
      o = 1'b0;
      r = 0;
      v = 0;
      case (f)
         4'd0, 4'd1: begin
            if (f == 4'd0) r = longint'($signed(s1)) + longint'($signed(s0));
            else           r = longint'($signed(s1)) - longint'($signed(s0));
            if (r > 32767)       begin d = 16'h7FFF; o = 1'b1; end
            else if (r < -32768) begin d = 16'h8000; o = 1'b1; end
            else                 d = r[15:0];
         end
         4'd2: d = s1 & s0;
         4'd3: d = ~(s1 | s0);
         4'd4: d = (sh >= 4'd15 && 32'(sh) >= 32'd16) ? 16'h0000 : 16'(s1 << sh);
         4'd5: d = s1 >> sh;
         4'd6: begin
            v = int'($signed(s1));
            v = v >>> sh;
            d = v[15:0];
         end
         4'd7: d = {s1[7:0], s0[7:0]};
`ifdef ALU_MUL_EN
         4'd8: begin
            r = longint'($signed(s1)) * longint'($signed(s0));
            if (r > 32767)       begin d = 16'h7FFF; o = 1'b1; end
            else if (r < -32768) begin d = 16'h8000; o = 1'b1; end
            else                 d = r[15:0];
         end
`endif
         default: begin d = 16'h0000; o = 1'b0; end
      endcase
   endfunction

   // Issue one op at the negedge and check its result when it appears.
   task automatic op_exp(input logic [3:0] f, input logic [15:0] s1, input logic [15:0] s0,
                         input logic [3:0] sh, input logic [15:0] ed, input logic eo,
                         input string nm);
      @(negedge clk);
      chk({nm, ".in_rdy"}, 32'(in_rdy), 32'd1);
      in_vld = 1'b1; func = f; src1 = s1; src0 = s0; shamt = sh;
      @(posedge clk); #1;
`ifdef ALU_MUL_EN
      if (f == 4'd8) begin
         int lat;
         int low;
         in_vld = 1'b0;
         lat = 0;
         low = 0;
         while (out_vld !== 1'b1 && lat < 40) begin
            if (in_rdy === 1'b0) low++;
            @(posedge clk); #1;
            lat++;
         end
         chk({nm, ".mul_lat"}, 32'(lat), 32'd16);
         chk({nm, ".rdy_low"}, 32'(low), 32'd16);
      end
`endif
      chk({nm, ".out_vld"}, 32'(out_vld), 32'd1);
      chk({nm, ".dst"}, 32'(dst), 32'(ed));
      chk({nm, ".ov"}, 32'(ov), 32'(eo));
      chk({nm, ".zr"}, 32'(zr), 32'(ed == 16'h0000));
      chk({nm, ".neg"}, 32'(neg), 32'(ed[15]));
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] ed;
      logic        eo;
      logic [3:0]  rf;
      logic [15:0] r1, r0;
      logic [3:0]  rs;
      int          pulses;

      rst_n = 1'b0; in_vld = 1'b0; func = 4'd0; src0 = 16'h0; src1 = 16'h0; shamt = 4'd0;
      #1;
      chk("rst.dst", 32'(dst), 32'd0);
      chk("rst.ov", 32'(ov), 32'd0);
      chk("rst.zr", 32'(zr), 32'd0);
      chk("rst.neg", 32'(neg), 32'd0);
      chk("rst.out_vld", 32'(out_vld), 32'd0);
      chk("rst.in_rdy", 32'(in_rdy), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors: f, src1, src0, shamt, expected dst, expected ov
      vq.push_back('{4'd0, 16'h7000, 16'h2000, 4'd0, 16'h7FFF, 1'b1});
      vq.push_back('{4'd1, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b1});
      vq.push_back('{4'd1, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1'b0});
      vq.push_back('{4'd0, 16'h8000, 16'hFFFF, 4'd0, 16'h8000, 1'b1});
      vq.push_back('{4'd1, 16'h0000, 16'h8000, 4'd0, 16'h7FFF, 1'b1});
      vq.push_back('{4'd0, 16'h1234, 16'h4321, 4'd0, 16'h5555, 1'b0});
      vq.push_back('{4'd1, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 1'b0});
      vq.push_back('{4'd2, 16'hF0F0, 16'h3C3C, 4'd0, 16'h3030, 1'b0});
      vq.push_back('{4'd3, 16'hF0F0, 16'h0F00, 4'd0, 16'h000F, 1'b0});
      vq.push_back('{4'd4, 16'h00FF, 16'h0000, 4'd8, 16'hFF00, 1'b0});
      vq.push_back('{4'd5, 16'h8001, 16'h0000, 4'd4, 16'h0800, 1'b0});
      vq.push_back('{4'd6, 16'h8001, 16'h0000, 4'd4, 16'hF800, 1'b0});
      vq.push_back('{4'd6, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1'b0});
      vq.push_back('{4'd5, 16'hFFFF, 16'h0000, 4'd15, 16'h0001, 1'b0});
      vq.push_back('{4'd7, 16'h12AB, 16'h34CD, 4'd0, 16'hABCD, 1'b0});
      vq.push_back('{4'd15, 16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b0});
      vq.push_back('{4'd9, 16'hFFFF, 16'hFFFF, 4'd0, 16'h0000, 1'b0});
`ifdef ALU_MUL_EN
      vq.push_back('{4'd8, 16'hFFFD, 16'h0005, 4'd0, 16'hFFF1, 1'b0});
      vq.push_back('{4'd8, 16'h0100, 16'h0100, 4'd0, 16'h7FFF, 1'b1});
      vq.push_back('{4'd8, 16'h8000, 16'h8000, 4'd0, 16'h7FFF, 1'b1});
      vq.push_back('{4'd8, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b0});
      vq.push_back('{4'd8, 16'hFF00, 16'h0100, 4'd0, 16'h8000, 1'b1});
`else
      vq.push_back('{4'd8, 16'hFFFD, 16'h0005, 4'd0, 16'h0000, 1'b0});
`endif
      for (int i = 0; i < vq.size(); i++) begin
         op_exp(vq[i].f, vq[i].s1, vq[i].s0, vq[i].sh, vq[i].ed, vq[i].eo, $sformatf("vec%0d", i));
      end

      // Between results: pulse drops and dst/flags hold.
      op_exp(4'd1, 16'h0001, 16'h0003, 4'd0, 16'hFFFE, 1'b0, "pre_hold");
      idle(3);
      chk("hold.out_vld", 32'(out_vld), 32'd0);
      chk("hold.dst", 32'(dst), 32'hFFFE);
      chk("hold.neg", 32'(neg), 32'd1);

      // Back-to-back ADDs: n + 1 for n = 0..7, one result per cycle.
      for (int n = 0; n < 8; n++) begin
         op_exp(4'd0, 16'(n), 16'h0001, 4'd0, 16'(n + 1), 1'b0, $sformatf("b2b%0d", n));
      end
      idle(1);
      chk("b2b_end.out_vld", 32'(out_vld), 32'd0);

      // Asynchronous reset mid-cycle clears outputs at once.
      op_exp(4'd0, 16'h1234, 16'h0001, 4'd0, 16'h1235, 1'b0, "pre_arst");
      @(negedge clk);
      in_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst.dst", 32'(dst), 32'd0);
      chk("arst.out_vld", 32'(out_vld), 32'd0);
      chk("arst.in_rdy", 32'(in_rdy), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

`ifdef ALU_MUL_EN
      // ADD held on in_vld during BUSY is taken only after in_rdy rises.
      begin
         int cyc;
         @(negedge clk);
         in_vld = 1'b1; func = 4'd8; src1 = 16'hFFFD; src0 = 16'h0005; shamt = 4'd0;
         @(posedge clk); #1;
         @(negedge clk);
         func = 4'd0; src1 = 16'h1111; src0 = 16'h2222;
         cyc = 0;
         while (out_vld !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("held.mul_lat", 32'(cyc), 32'd16);
         chk("held.mul_dst", 32'(dst), 32'hFFF1);
         @(posedge clk); #1;
         chk("held.add_vld", 32'(out_vld), 32'd1);
         chk("held.add_dst", 32'(dst), 32'h3333);
         idle(1);
      end

      // Reset 5 cycles into BUSY: abort, no late pulse.
      @(negedge clk);
      in_vld = 1'b1; func = 4'd8; src1 = 16'h0100; src0 = 16'h0100; shamt = 4'd0;
      @(posedge clk); #1;
      in_vld = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst.dst", 32'(dst), 32'd0);
      chk("mrst.in_rdy", 32'(in_rdy), 32'd1);
      chk("mrst.out_vld", 32'(out_vld), 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_vld === 1'b1) pulses++;
      end
      chk("mrst.no_pulse", 32'(pulses), 32'd0);
      op_exp(4'd0, 16'h0002, 16'h0003, 4'd0, 16'h0005, 1'b0, "mrst_add");
`else
      pulses = 0;
      op_exp(4'd0, 16'h0002, 16'h0003, 4'd0, 16'h0005, 1'b0, "post_arst_add");
`endif

      // Random ops against the reference model.
      for (int k = 0; k < 300; k++) begin
         rf = 4'($urandom_range(0, 15));
         r1 = 16'($urandom);
         r0 = 16'($urandom);
         rs = 4'($urandom);
         if (k % 4 == 0) r1 = {r1[15], 15'($urandom_range(0, 3)) ^ {15{r1[15]}}};
         ref_op(rf, r1, r0, rs, ed, eo);
         op_exp(rf, r1, r0, rs, ed, eo, $sformatf("rnd%0d_f%0d", k, rf));
         if (k % 17 == 0) idle(1);
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
